mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single physical data-memory port between two masters:
  - the pipelined CPU's data/memory stage (address, byte-enable write, read data);
  - a secondary bus master (DMA or peripheral engine) using a valid/ready handshake.
- The CPU has priority. A bounded-starvation counter guarantees the DMA master one slot after at most STREAK_MAX consecutive contested CPU grants.
- The CPU is stalled on the cycles it loses.
- Sits between the CPU core's data port and the memory block's data port (18-bit word address, 32-bit data, 1-cycle synchronous read).

Parameters:
- STREAK_MAX, 4, max consecutive CPU grants while the DMA master is waiting (legal range 1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_valid  in  1  CPU requests a memory access this cycle
- cpu_addr  in  18  CPU word address
- cpu_we  in  4  CPU byte write enables (0 = read)
- cpu_wdata  in  32  CPU store data
- cpu_rdata  out  32  read data to CPU (valid the cycle after a CPU read grant)
- cpu_stall  out  1  CPU request not granted this cycle; CPU must hold its request
- dma_valid  in  1  DMA request pending
- dma_ready  out  1  DMA request granted this cycle
- dma_addr  in  18  DMA word address
- dma_we  in  4  DMA byte write enables (0 = read)
- dma_wdata  in  32  DMA store data
- dma_rdata  out  32  read data to DMA
- dma_rvalid  out  1  dma_rdata valid (pulse one cycle after a granted DMA read)
- mem_addr  out  18  memory port address
- mem_we  out  4  memory port byte write enables
- mem_wdata  out  32  memory port write data
- mem_rdata  in  32  memory port read data (1-cycle latency)

Behaviour:
- Registered state:
  - streak: 8-bit, counts consecutive CPU grants while the DMA master waits;
  - rd_dma: 1-bit, the previous cycle was a DMA read grant.
- Grant decision (combinational, same cycle), from inputs and streak:
  - gnt_dma = dma_valid && (!cpu_valid || streak == STREAK_MAX)
  - gnt_cpu = cpu_valid && !gnt_dma
  - No grant when neither master is valid.
  - During rst: gnt_dma = gnt_cpu = 0.
- Memory mux:
  - gnt_dma: mem_* = dma_*.
  - gnt_cpu: mem_* = cpu_*.
  - No grant: mem_addr = cpu_addr, mem_wdata = cpu_wdata, mem_we = 0. A write is never issued without a grant.
- Handshake and stall outputs:
  - dma_ready = gnt_dma.
  - A DMA transfer occurs on dma_valid && dma_ready.
  - While dma_valid && !dma_ready, the DMA master holds addr/we/wdata stable.
  - cpu_stall = cpu_valid && gnt_dma && !rst.
  - The CPU re-presents a stalled request unchanged.
- Streak counter, on each clk edge:
  - rst: 0.
  - else if gnt_dma or !dma_valid: 0.
  - else if gnt_cpu: saturating increment, capped at STREAK_MAX.
  - else: hold.
- Read return:
  - rd_dma <= !rst && gnt_dma && (dma_we == 0).
  - dma_rvalid = rd_dma.
  - dma_rdata = mem_rdata; cpu_rdata = mem_rdata (pass-through, no extra latency).
  - Read latency is exactly 1 cycle from grant for both masters.
- Reset values: streak = 0, rd_dma = 0, dma_rvalid = 0, dma_ready = 0, cpu_stall = 0, mem_we = 0 while rst is high.
- Boundary conditions:
  - Reset mid-operation: a DMA read granted in the cycle before rst still has its dma_rvalid suppressed if rst is high in the return cycle. Use rd_dma gated by !rst on the output.
  - STREAK_MAX = 1: CPU and DMA strictly alternate under continuous contention.
  - Simultaneous request at streak < STREAK_MAX: CPU wins.
  - dma_valid dropping mid-wait: counter clears; fairness is not carried across requests.
  - Back-to-back DMA grants: allowed whenever cpu_valid = 0.
  - Write grants never produce dma_rvalid.
- No combinational path from mem_rdata to any control output.

Test Plan:
- Reset with cpu_valid = 1 and dma_valid = 1 held high:
  - required: mem_we = 0, dma_ready = 0, cpu_stall = 0, dma_rvalid = 0.
  - after rst falls: first grant to CPU.
- CPU only, read 0x00010 then write 0x00011 with cpu_we = 4'hF, wdata = 32'hDEADBEEF:
  - required: cpu_stall = 0 throughout.
  - mem_addr follows the CPU.
  - mem_we = 4'hF on the write cycle only.
- Continuous contention, STREAK_MAX = 4, both valid for 15 cycles:
  - required grant pattern C,C,C,C,D,C,C,C,C,D,...
  - cpu_stall high exactly on the D cycles.
  - streak reads 0,1,2,3,4,0.
- DMA-only read of 0x3FFFF with memory returning 32'h12345678:
  - required: dma_ready = 1 in cycle N.
  - dma_rvalid = 1 with dma_rdata = 32'h12345678 in cycle N+1.
  - no dma_rvalid for a DMA write with dma_we = 4'h3.
- DMA read granted in cycle N, rst asserted in cycle N+1:
  - required: dma_rvalid = 0 in N+1 and N+2.
  - streak = 0 after reset.
- dma_valid deasserted after 2 contested CPU grants, then reasserted:
  - required: streak restarts at 0.
  - DMA waits a full 4 CPU grants again.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the single data-memory port: the CPU has priority and
// the DMA master is guaranteed a slot after STREAK_MAX contested CPU grants.
module mem_port_arbiter #(
  parameter int STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_valid,
  input  logic [17:0] cpu_addr,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_valid,
  output logic        dma_ready,
  input  logic [17:0] dma_addr,
  input  logic [3:0]  dma_we,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_rvalid,
  output logic [17:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] STREAK_CAP = 8'(STREAK_MAX);

  logic [7:0] streak_q, streak_d;
  logic       rd_dma_q, rd_dma_d;
  logic       gnt_dma, gnt_cpu;

  function automatic logic [7:0] sat_inc(input logic [7:0] val);
    return (val >= STREAK_CAP) ? STREAK_CAP : val + 8'd1;
  endfunction

  always_comb begin
    gnt_dma = !rst && dma_valid && (!cpu_valid || streak_q == STREAK_CAP);
    gnt_cpu = !rst && cpu_valid && !gnt_dma;
  end

  // With no grant the port idles on the CPU address with writes suppressed.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 4'h0;
    if (gnt_dma) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we;
    end else if (gnt_cpu) begin
      mem_we    = cpu_we;
    end
  end

  // Fairness is per request: a withdrawn DMA request forfeits its accumulated wait.
  always_comb begin
    streak_d = streak_q;
    if (rst || gnt_dma || !dma_valid) begin
      streak_d = 8'd0;
    end else if (gnt_cpu) begin
      streak_d = sat_inc(streak_q);
    end
    rd_dma_d = gnt_dma && (dma_we == 4'h0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= 8'd0;
      rd_dma_q <= 1'b0;
    end else begin
      streak_q <= streak_d;
      rd_dma_q <= rd_dma_d;
    end
  end

  assign dma_ready  = gnt_dma;
  assign cpu_stall  = cpu_valid && gnt_dma;
  assign dma_rvalid = rd_dma_q && !rst;
  assign dma_rdata  = mem_rdata;
  assign cpu_rdata  = mem_rdata;

endmodule
